fwd_unit: RTL and testbench
===========================

# fwd_unit

Parametrised operand-forwarding and load-use interlock unit for the pipelined datapath. It sits in the ID stage and generalises the fixed 16-bit, single-operand forwarding mux into NPORTS operand channels of DW bits. It tracks the destination tags of the two in-flight instructions (EX and MEM slots) in its own tag pipeline and selects each operand from the register file, the low or high half of the EX ALU result, or MEM-stage data. It also raises a one-cycle stall on a load-use hazard.

## Interface
- DW, 16: operand/data width; the EX result is 2*DW.
- RW, 4: register-address width.
- NPORTS, 2: number of source operands per instruction.
- ZERO_REG, 1: when 1, register 0 is hardwired zero and never forwarded.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_src  in  NPORTS*RW  source register of each port; port p is bits [p*RW +: RW].
- id_rf_data  in  NPORTS*DW  register-file read data per port.
- id_wr_en  in  1  ID instruction writes a register.
- id_dest  in  RW  ID destination register.
- id_kind  in  2  result kind: 00 ALU_LO, 01 ALU_HI, 10 LOAD, 11 reserved (treated as ALU_LO).
- flush  in  1  kill the instruction entering EX (branch redirect).
- ex_result  in  2*DW  ALU result of the EX-slot instruction.
- mem_data  in  DW  value the MEM-slot instruction will write back: load data or carried ALU value.
- op_out  out  NPORTS*DW  forwarded operands.
- stall  out  1  hold PC and IF/ID; insert a bubble into EX.

## Operation
- State: two tag slots, EX and MEM. Each slot holds {valid, dest, kind}.
- A slot matches port p when all of the following hold: slot valid, slot dest == id_src[p], id_valid, and not (ZERO_REG and id_src[p] == 0).
- Per-port select, in priority order:
  1. EX match with kind ALU_LO: op = ex_result[DW-1:0].
  2. EX match with kind ALU_HI: op = ex_result[2DW-1:DW].
  3. EX match with kind LOAD: hazard. op = id_rf_data (don't-care).
  4. MEM match: op = mem_data.
  5. Otherwise: op = id_rf_data[p].
- EX beats MEM, so the youngest producer wins.
- stall = OR over ports of rule 3.
- Slot update on each clk edge:
  - MEM <= EX.
  - EX <= {id_valid & id_wr_en & ~stall & ~flush, id_dest, id_kind}.
  - During stall, EX receives a bubble (valid=0) and the upstream holds ID. Next cycle the load sits in MEM and forwards through rule 4, so stall falls.
- flush and stall together: EX gets a bubble; flush has no further effect.
- The register file is write-through: a WB-stage write is visible on id_rf_data in the same cycle, so no third slot exists.
- An instruction with id_wr_en=0 never occupies a valid slot.

## Timing
- Reset (rst_n low, asynchronous): both slots invalid. stall=0. op_out = id_rf_data (purely combinational from inputs).
- op_out and stall are combinational from the slots and ID inputs, with zero latency. Slots update only on rising clk.
- Load-use: stall is high for exactly 1 cycle per dependent instruction.
- Back-to-back dependent ALU ops need 0 stall cycles.
- Reset asserted mid-stall: stall drops immediately because the slots clear.

## Structure
- A shared package dp_pkg holds the kind_t encoding (ALU_LO, ALU_HI, LOAD) and a slot_t struct {valid, dest, kind}.
- One sub-module, fwd_port_sel: per-port match, priority and mux logic, instantiated NPORTS times via generate. It outputs op and hazard.
- The top holds the slot registers and the stall OR-reduce.

## Test plan
- Reset: pulse rst_n low, then drive id_src=2/3 with rf data 0x1111/0x2222 -> op_out = 0x2222_1111, stall=0.
- ALU chain: cycle 0 writes r5 as ALU_LO. Cycle 1 reads r5 on port 0 with ex_result=0xABCD_1234 -> op0=0x1234, stall=0. Cycle 2 with a new ID instruction also reading r5 and mem_data=0x1234 -> op0=0x1234 through MEM.
- High half: r6 producer of kind ALU_HI, ex_result=0xBEEF_0001, consumer reads r6 on port 1 the next cycle -> op1=0xBEEF.
- Load-use: LOAD r4, then the next instruction reads r4 -> stall=1 for one cycle. Next cycle with mem_data=0x5A5A -> stall=0, op0=0x5A5A.
- Priority and r0: r7 in both EX (ALU_LO, low half 0x0007) and MEM (mem_data 0x0070) -> op=0x0007. Reading r0 while a slot holds dest 0 -> op=id_rf_data.
- Flush: producer of r3 enters with flush=1, then a consumer reads r3 -> op = id_rf_data, stall=0.

Source files
------------

// File: rtl/dp_pkg.sv
// Shared datapath types: result-kind encoding and the in-flight tag slot
// tracked by the forwarding unit.
package dp_pkg;

    // Upper bound on register-address width; slot dests are stored zero-extended to this.
    localparam int SLOT_RW = 8;

    typedef enum logic [1:0] {
        KIND_ALU_LO = 2'b00,
        KIND_ALU_HI = 2'b01,
        KIND_LOAD   = 2'b10,
        KIND_RSVD   = 2'b11
    } kind_t;

    typedef struct packed {
        logic               valid;
        logic [SLOT_RW-1:0] dest;
        kind_t              kind;
    } slot_t;

endpackage

// File: rtl/fwd_port_sel.sv
// One operand channel: matches its source register against the EX and MEM
// tag slots and picks register-file data, an EX result half, or MEM data.
module fwd_port_sel
    import dp_pkg::*;
#(
    parameter int DW       = 16,
    parameter int RW       = 4,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic            id_valid,
    input  logic [RW-1:0]   src,
    input  logic [DW-1:0]   rf_data,
    input  slot_t           ex_slot,
    input  slot_t           mem_slot,
    input  logic [2*DW-1:0] ex_result,
    input  logic [DW-1:0]   mem_data,
    output logic [DW-1:0]   op,
    output logic            hazard
);

    logic [SLOT_RW-1:0] src_ext;
    logic               zero_src;
    logic               ex_match;
    logic               mem_match;
    logic [1:0]         mem_kind_unused;

    assign src_ext   = SLOT_RW'(src);
    assign zero_src  = ZERO_REG && (src == '0);
    assign ex_match  = ex_slot.valid  && (ex_slot.dest  == src_ext) && id_valid && !zero_src;
    assign mem_match = mem_slot.valid && (mem_slot.dest == src_ext) && id_valid && !zero_src;

    // MEM data is already the final write-back value, so its kind is irrelevant here.
    assign mem_kind_unused = mem_slot.kind;

    always_comb begin
        op     = rf_data;
        hazard = 1'b0;
        if (ex_match) begin
            case (ex_slot.kind)
                KIND_ALU_HI: op     = ex_result[2*DW-1:DW];
                KIND_LOAD:   hazard = 1'b1;
                default:     op     = ex_result[DW-1:0];
            endcase
        end else if (mem_match) begin
            op = mem_data;
        end
    end

endmodule

// File: rtl/fwd_unit.sv
// ID-stage operand forwarding and load-use interlock: keeps the EX/MEM tag
// pipeline and steers NPORTS operands from the youngest in-flight producer.
module fwd_unit
    import dp_pkg::*;
#(
    parameter int DW       = 16,
    parameter int RW       = 4,
    parameter int NPORTS   = 2,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic [NPORTS*RW-1:0] id_src,
    input  logic [NPORTS*DW-1:0] id_rf_data,
    input  logic                 id_wr_en,
    input  logic [RW-1:0]        id_dest,
    input  logic [1:0]           id_kind,
    input  logic                 flush,
    input  logic [2*DW-1:0]      ex_result,
    input  logic [DW-1:0]        mem_data,
    output logic [NPORTS*DW-1:0] op_out,
    output logic                 stall
);

    slot_t             ex_q;
    slot_t             mem_q;
    slot_t             ex_d;
    logic [NPORTS-1:0] hazard;

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        fwd_port_sel #(
            .DW       (DW),
            .RW       (RW),
            .ZERO_REG (ZERO_REG)
        ) u_sel (
            .id_valid  (id_valid),
            .src       (id_src[p*RW +: RW]),
            .rf_data   (id_rf_data[p*DW +: DW]),
            .ex_slot   (ex_q),
            .mem_slot  (mem_q),
            .ex_result (ex_result),
            .mem_data  (mem_data),
            .op        (op_out[p*DW +: DW]),
            .hazard    (hazard[p])
        );
    end

    assign stall = |hazard;

    // A stalled or flushed instruction enters EX as a bubble; ID is held upstream.
    always_comb begin
        ex_d       = '0;
        ex_d.valid = id_valid & id_wr_en & ~stall & ~flush;
        ex_d.dest  = SLOT_RW'(id_dest);
        ex_d.kind  = kind_t'(id_kind);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
        end else begin
            mem_q <= ex_q;
            ex_q  <= ex_d;
        end
    end

endmodule

// File: tb/tb_fwd_unit.sv
// Self-checking bench for fwd_unit: a cycle table plus a reset-during-stall sequence.
module tb_fwd_unit;

    localparam int DW     = 16;
    localparam int RW     = 4;
    localparam int NPORTS = 2;

    logic                 clk;
    logic                 rst_n;
    logic                 id_valid;
    logic [NPORTS*RW-1:0] id_src;
    logic [NPORTS*DW-1:0] id_rf_data;
    logic                 id_wr_en;
    logic [RW-1:0]        id_dest;
    logic [1:0]           id_kind;
    logic                 flush;
    logic [2*DW-1:0]      ex_result;
    logic [DW-1:0]        mem_data;
    logic [NPORTS*DW-1:0] op_out;
    logic                 stall;

    fwd_unit #(.DW(DW), .RW(RW), .NPORTS(NPORTS), .ZERO_REG(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_src     (id_src),
        .id_rf_data (id_rf_data),
        .id_wr_en   (id_wr_en),
        .id_dest    (id_dest),
        .id_kind    (id_kind),
        .flush      (flush),
        .ex_result  (ex_result),
        .mem_data   (mem_data),
        .op_out     (op_out),
        .stall      (stall)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- vector records ----------------
    typedef struct {
        logic            v;
        logic [RW-1:0]   s0, s1;
        logic [DW-1:0]   r0, r1;
        logic            we;
        logic [RW-1:0]   d;
        logic [1:0]      k;
        logic            fl;
        logic [2*DW-1:0] exr;
        logic [DW-1:0]   mem;
        logic [2*DW-1:0] eop;
        logic            est;
    } vec_t;

    vec_t            vecs[$];
    logic [2*DW:0]   exp_q[$];
    int              n_vec;
    int              n_miss;

    task automatic add(input logic v, input logic [RW-1:0] s0, input logic [RW-1:0] s1,
                       input logic [DW-1:0] r0, input logic [DW-1:0] r1, input logic we,
                       input logic [RW-1:0] d, input logic [1:0] k, input logic fl,
                       input logic [2*DW-1:0] exr, input logic [DW-1:0] mem,
                       input logic [2*DW-1:0] eop, input logic est);
        vec_t t;
        t.v = v; t.s0 = s0; t.s1 = s1; t.r0 = r0; t.r1 = r1; t.we = we;
        t.d = d; t.k = k; t.fl = fl; t.exr = exr; t.mem = mem; t.eop = eop; t.est = est;
        vecs.push_back(t);
    endtask

    // ---------------- driver ----------------
    task automatic drive(input vec_t t);
        id_valid   = t.v;
        id_src     = {t.s1, t.s0};
        id_rf_data = {t.r1, t.r0};
        id_wr_en   = t.we;
        id_dest    = t.d;
        id_kind    = t.k;
        flush      = t.fl;
        ex_result  = t.exr;
        mem_data   = t.mem;
        exp_q.push_back({t.est, t.eop});
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name);
        logic [2*DW:0] e;
        logic [2*DW:0] a;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_miss++;
            $display("FAIL %s: no expected entry queued", name);
            return;
        end
        e = exp_q.pop_front();
        a = {stall, op_out};
        if (a !== e) begin
            n_miss++;
            $display("FAIL %s: got stall=%0b op_out=%h, expected stall=%0b op_out=%h",
                     name, a[2*DW], a[2*DW-1:0], e[2*DW], e[2*DW-1:0]);
        end
    endtask

    task automatic step(input vec_t t, input string name);
        @(posedge clk);
        #1;
        drive(t);
        @(negedge clk);
        check(name);
    endtask

    initial begin
        vec_t t;
        n_vec  = 0;
        n_miss = 0;
        rst_n  = 1'b0;

        //  v  s0     s1     r0        r1        we d      k  fl exr             mem       eop             est
        add(1, 4'd2,  4'd3,  16'h1111, 16'h2222, 0, 4'd0,  0, 0, 32'h0,          16'h0,    32'h2222_1111, 0); // after reset
        add(1, 4'd1,  4'd2,  16'h0101, 16'h0202, 1, 4'd5,  0, 0, 32'h0,          16'h0,    32'h0202_0101, 0); // r5 ALU_LO
        add(1, 4'd5,  4'd2,  16'h0505, 16'h0202, 0, 4'd0,  0, 0, 32'hABCD_1234,  16'h0,    32'h0202_1234, 0); // EX fwd
        add(1, 4'd5,  4'd9,  16'h0555, 16'h0909, 0, 4'd0,  0, 0, 32'hFFFF_FFFF,  16'h1234, 32'h0909_1234, 0); // MEM fwd
        add(1, 4'd1,  4'd1,  16'h0101, 16'h0101, 1, 4'd6,  1, 0, 32'h0,          16'h0,    32'h0101_0101, 0); // r6 ALU_HI
        add(1, 4'd2,  4'd6,  16'h0202, 16'h0606, 0, 4'd0,  0, 0, 32'hBEEF_0001,  16'h0,    32'hBEEF_0202, 0); // high half
        add(1, 4'd6,  4'd3,  16'h0606, 16'h0303, 0, 4'd0,  0, 0, 32'h0,          16'h7777, 32'h0303_7777, 0); // MEM any kind
        add(1, 4'd1,  4'd2,  16'h0101, 16'h0202, 1, 4'd4,  2, 0, 32'h0,          16'h0,    32'h0202_0101, 0); // LOAD r4
        add(1, 4'd4,  4'd2,  16'h0404, 16'h0202, 1, 4'd8,  0, 0, 32'h1234_5678,  16'h0,    32'h0202_0404, 1); // load-use
        add(1, 4'd4,  4'd2,  16'h0404, 16'h0202, 1, 4'd8,  0, 0, 32'h1234_5678,  16'h5A5A, 32'h0202_5A5A, 0); // released
        add(1, 4'd3,  4'd8,  16'h0303, 16'h0808, 0, 4'd0,  0, 0, 32'h0000_00C8,  16'h5A5A, 32'h00C8_0303, 0); // held instr fwd
        add(1, 4'd1,  4'd2,  16'h0101, 16'h0202, 1, 4'd7,  0, 0, 32'h0,          16'h0,    32'h0202_0101, 0); // r7
        add(1, 4'd3,  4'd2,  16'h0303, 16'h0202, 1, 4'd7,  0, 0, 32'h0000_0070,  16'h0,    32'h0202_0303, 0); // r7 again
        add(1, 4'd7,  4'd7,  16'h0777, 16'h0777, 1, 4'd0,  0, 0, 32'hDEAD_0007,  16'h0070, 32'h0007_0007, 0); // EX beats MEM
        add(1, 4'd0,  4'd0,  16'h1357, 16'h2468, 1, 4'd0,  0, 0, 32'hFFFF_FFFF,  16'h9999, 32'h2468_1357, 0); // r0 vs EX
        add(1, 4'd0,  4'd0,  16'h1111, 16'h2222, 0, 4'd0,  0, 0, 32'hFFFF_FFFF,  16'h9999, 32'h2222_1111, 0); // r0 vs both
        add(1, 4'd1,  4'd2,  16'h0101, 16'h0202, 1, 4'd3,  0, 1, 32'h0,          16'h0,    32'h0202_0101, 0); // flushed r3
        add(1, 4'd3,  4'd3,  16'h0333, 16'h0333, 0, 4'd0,  0, 0, 32'hAAAA_BBBB,  16'hCCCC, 32'h0333_0333, 0); // no fwd
        add(1, 4'd1,  4'd2,  16'h0101, 16'h0202, 1, 4'd4,  2, 0, 32'h0,          16'h0,    32'h0202_0101, 0); // LOAD r4
        add(1, 4'd4,  4'd2,  16'h0404, 16'h0202, 1, 4'd5,  0, 1, 32'h0,          16'h0,    32'h0202_0404, 1); // stall+flush
        add(1, 4'd5,  4'd4,  16'h0505, 16'h0404, 0, 4'd0,  0, 0, 32'h0000_0055,  16'h4444, 32'h4444_0505, 0); // bubble in EX
        add(1, 4'd1,  4'd2,  16'h0101, 16'h0202, 1, 4'd9,  0, 0, 32'h0,          16'h0,    32'h0202_0101, 0); // r9
        add(0, 4'd9,  4'd2,  16'h0909, 16'h0202, 1, 4'd10, 0, 0, 32'h0000_0099,  16'h0,    32'h0202_0909, 0); // id_valid=0
        add(1, 4'd10, 4'd2,  16'h0A0A, 16'h0202, 0, 4'd0,  0, 0, 32'h0000_00AA,  16'h0,    32'h0202_0A0A, 0); // no slot for r10
        add(1, 4'd1,  4'd2,  16'h0101, 16'h0202, 1, 4'd11, 3, 0, 32'h0,          16'h0,    32'h0202_0101, 0); // reserved kind
        add(1, 4'd2,  4'd11, 16'h0202, 16'h0B0B, 0, 4'd0,  0, 0, 32'h1111_2222,  16'h0,    32'h2222_0202, 0); // as ALU_LO
        add(1, 4'd1,  4'd2,  16'h0101, 16'h0202, 1, 4'd12, 0, 0, 32'h0,          16'h0,    32'h0202_0101, 0); // r12
        add(1, 4'd1,  4'd2,  16'h0101, 16'h0202, 1, 4'd13, 0, 0, 32'h0,          16'h0,    32'h0202_0101, 0); // r13
        add(1, 4'd12, 4'd13, 16'h0C0C, 16'h0D0D, 0, 4'd0,  0, 0, 32'h0000_00DD,  16'h00CC, 32'h00DD_00CC, 0); // split slots

        // Outputs during reset follow the register file.
        #1;
        drive(vecs[0]);
        @(negedge clk);
        check("in_reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset asserted while a load-use stall is showing.
        t = vecs[18];
        step(t, "midstall_load");
        t = vecs[19];
        t.fl = 1'b0;
        step(t, "midstall_pre");
        #1;
        rst_n = 1'b0;
        t.est = 1'b0;
        exp_q.push_back({t.est, t.eop});
        #1;
        check("midstall_rst");
        @(negedge clk);
        rst_n = 1'b1;
        t = vecs[19];
        t.est = 1'b0;
        step(t, "post_rst_consumer");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
